// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared types and derived-width helpers for the L1 controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

   typedef enum logic [1:0] {
      MESI_I = 2'b00,
      MESI_S = 2'b01,
      MESI_E = 2'b10,
      MESI_M = 2'b11
   } mesi_t;

   typedef enum logic [3:0] {
      OP_RD      = 4'd0,
      OP_WR      = 4'd1,
      OP_IRD     = 4'd2,
      OP_SNP_INV = 4'd3,
      OP_SNP_RD  = 4'd4,
      OP_SNP_RFO = 4'd5,
      OP_CLEAR   = 4'd8,
      OP_NOP     = 4'd15
   } op_t;

   typedef enum logic [1:0] {
      BUS_READ       = 2'd0,
      BUS_RFO        = 2'd1,
      BUS_WRITEBACK  = 2'd2,
      BUS_INVALIDATE = 2'd3
   } bus_op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_CMP  = 3'd2,
      ST_WB   = 3'd3,
      ST_BUS  = 3'd4,
      ST_UPD  = 3'd5,
      ST_CLR  = 3'd6,
      ST_DONE = 3'd7
   } state_t;

   function automatic int calc_index_w(input int cache_log, input int line_log, input int ways);
      return cache_log - line_log - $clog2(ways);
   endfunction

   function automatic int calc_tag_w(input int addr_w, input int cache_log,
                                     input int line_log, input int ways);
      return addr_w - calc_index_w(cache_log, line_log, ways) - line_log;
   endfunction

   // Unlisted encodings collapse to NOP so the FSM never sees an illegal op.
   function automatic op_t decode_op(input logic [3:0] raw);
      case (raw)
         4'd0:    return OP_RD;
         4'd1:    return OP_WR;
         4'd2:    return OP_IRD;
         4'd3:    return OP_SNP_INV;
         4'd4:    return OP_SNP_RD;
         4'd5:    return OP_SNP_RFO;
         4'd8:    return OP_CLEAR;
         default: return OP_NOP;
      endcase
   endfunction

   function automatic logic is_cpu_op(input op_t op);
      return (op == OP_RD) || (op == OP_WR) || (op == OP_IRD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_plru_tree.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree
// Description : Tree pseudo-LRU: victim lookup and touch update (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module plru_tree #(
   parameter int WAYS = 8,
   localparam int c_way_w  = $clog2(WAYS),
   localparam int c_node_w = $clog2(WAYS - 1)
) (
   input  logic [WAYS-2:0]    i_tree,
   input  logic [c_way_w-1:0] i_access_way,
   output logic [c_way_w-1:0] o_victim_way,
   output logic [WAYS-2:0]    o_new_tree
);

   // Node n has children 2n+1 (bit=0 side) and 2n+2 (bit=1 side).
   always_comb begin
      int n_v;
      n_v = 0;
      for (int l = 0; l < c_way_w; l++) begin
         n_v = 2 * n_v + 1 + int'(i_tree[c_node_w'(n_v)]);
      end
      o_victim_way = c_way_w'(n_v - (WAYS - 1));
   end

   // Each node on the path is pointed away from the accessed leaf.
   always_comb begin
      int n_t;
      int p_t;
      o_new_tree = i_tree;
      n_t        = int'(i_access_way) + WAYS - 1;
      p_t        = 0;
      for (int l = 0; l < c_way_w; l++) begin
         p_t = (n_t - 1) / 2;
         o_new_tree[c_node_w'(p_t)] = n_t[0];
         n_t = p_t;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Per-request sequencer for the 8-way MESI L1 model.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int CACHE_LOG = 24,
   parameter int LINE_LOG  = 6,
   parameter int WAYS      = 8,
   localparam int c_index_w = calc_index_w(CACHE_LOG, LINE_LOG, WAYS),
   localparam int c_tag_w   = calc_tag_w(ADDR_W, CACHE_LOG, LINE_LOG, WAYS),
   localparam int c_way_w   = $clog2(WAYS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [3:0]                req_op,
   input  logic [ADDR_W-1:0]         req_addr,
   output logic [c_index_w-1:0]      arr_index,
   output logic                      arr_rd_en,
   input  logic [WAYS*c_tag_w-1:0]   arr_tag,
   input  logic [2*WAYS-1:0]         arr_mesi,
   input  logic [WAYS-2:0]           arr_plru,
   output logic                      arr_wr_en,
   output logic [c_way_w-1:0]        arr_wr_way,
   output logic [c_tag_w-1:0]        arr_wr_tag,
   output logic [1:0]                arr_wr_mesi,
   output logic [WAYS-2:0]           arr_wr_plru,
   output logic                      bus_req_valid,
   output logic [1:0]                bus_op,
   output logic [ADDR_W-1:0]         bus_addr,
   input  logic                      bus_done,
   input  logic                      bus_shared,
   output logic                      done,
   output logic                      resp_hit,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count
);

   state_t                   r_state, w_next_state;
   op_t                      r_op;
   logic [c_tag_w-1:0]       r_tag;
   logic [c_index_w-1:0]     r_idx;
   logic [c_way_w-1:0]       r_way;
   mesi_t                    r_new_mesi;
   logic [WAYS-2:0]          r_new_plru;
   logic                     r_hit, r_need_bus;
   bus_op_t                  r_bus_op;
   logic [c_tag_w-1:0]       r_wb_tag;
   logic [c_index_w-1:0]     r_clr_idx;
   logic [c_way_w-1:0]       r_clr_way;
   logic [31:0]              r_hit_count, r_miss_count;

   logic                     w_hit, w_inv_found, w_victim_m;
   logic [c_way_w-1:0]       w_hit_way, w_inv_way, w_plru_victim, w_tgt_way;
   logic [WAYS-2:0]          w_plru_new;
   mesi_t                    w_tgt_mesi, w_cmp_mesi;
   logic [c_tag_w-1:0]       w_tgt_tag;
   state_t                   w_cmp_next;
   bus_op_t                  w_cmp_bus_op;
   logic                     w_cmp_need_bus;
   logic                     w_unused_offset;

   assign w_unused_offset = ^req_addr[LINE_LOG-1:0];
   assign hit_count       = r_hit_count;
   assign miss_count      = r_miss_count;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if ((arr_mesi[2*i +: 2] != MESI_I) && (arr_tag[i*c_tag_w +: c_tag_w] == r_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = c_way_w'(i);
         end
         if (arr_mesi[2*i +: 2] == MESI_I) begin
            w_inv_found = 1'b1;
            w_inv_way   = c_way_w'(i);
         end
      end
   end

   assign w_tgt_way  = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_plru_victim);
   assign w_victim_m = !w_hit && (w_tgt_mesi == MESI_M);

   always_comb begin
      w_tgt_mesi = MESI_I;
      w_tgt_tag  = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (w_tgt_way == c_way_w'(i)) begin
            w_tgt_mesi = mesi_t'(arr_mesi[2*i +: 2]);
            w_tgt_tag  = arr_tag[i*c_tag_w +: c_tag_w];
         end
      end
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .i_tree       (arr_plru),
      .i_access_way (w_tgt_way),
      .o_victim_way (w_plru_victim),
      .o_new_tree   (w_plru_new)
   );

   // Hit/miss resolution; read-miss final state is fixed later by bus_shared.
   always_comb begin
      w_cmp_next     = ST_DONE;
      w_cmp_mesi     = w_tgt_mesi;
      w_cmp_bus_op   = BUS_READ;
      w_cmp_need_bus = 1'b0;
      case (r_op)
         OP_RD, OP_IRD: begin
            if (w_hit) begin
               w_cmp_next = ST_UPD;
            end else begin
               w_cmp_need_bus = 1'b1;
               w_cmp_next     = w_victim_m ? ST_WB : ST_BUS;
            end
         end
         OP_WR: begin
            w_cmp_mesi = MESI_M;
            if (w_hit && (w_tgt_mesi == MESI_S)) begin
               w_cmp_need_bus = 1'b1;
               w_cmp_bus_op   = BUS_INVALIDATE;
               w_cmp_next     = ST_BUS;
            end else if (w_hit) begin
               w_cmp_next = ST_UPD;
            end else begin
               w_cmp_need_bus = 1'b1;
               w_cmp_bus_op   = BUS_RFO;
               w_cmp_next     = w_victim_m ? ST_WB : ST_BUS;
            end
         end
         OP_SNP_INV: begin
            if (w_hit && (w_tgt_mesi == MESI_S)) begin
               w_cmp_mesi = MESI_I;
               w_cmp_next = ST_UPD;
            end
         end
         OP_SNP_RD: begin
            if (w_hit && (w_tgt_mesi == MESI_M || w_tgt_mesi == MESI_E)) begin
               w_cmp_mesi = MESI_S;
               w_cmp_next = (w_tgt_mesi == MESI_M) ? ST_WB : ST_UPD;
            end
         end
         OP_SNP_RFO: begin
            if (w_hit) begin
               w_cmp_mesi = MESI_I;
               w_cmp_next = (w_tgt_mesi == MESI_M) ? ST_WB : ST_UPD;
            end
         end
         default: w_cmp_next = ST_DONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      req_ready     = 1'b0;
      arr_index     = '0;
      arr_rd_en     = 1'b0;
      arr_wr_en     = 1'b0;
      arr_wr_way    = '0;
      arr_wr_tag    = '0;
      arr_wr_mesi   = MESI_I;
      arr_wr_plru   = '0;
      bus_req_valid = 1'b0;
      bus_op        = BUS_READ;
      bus_addr      = '0;
      done          = 1'b0;
      resp_hit      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               case (decode_op(req_op))
                  OP_CLEAR: w_next_state = ST_CLR;
                  OP_NOP:   w_next_state = ST_DONE;
                  default: begin
                     arr_rd_en    = 1'b1;
                     arr_index    = req_addr[LINE_LOG +: c_index_w];
                     w_next_state = ST_READ;
                  end
               endcase
            end
         end
         ST_READ: w_next_state = ST_CMP;
         ST_CMP:  w_next_state = w_cmp_next;
         ST_WB: begin
            bus_req_valid = 1'b1;
            bus_op        = BUS_WRITEBACK;
            bus_addr      = {r_wb_tag, r_idx, {LINE_LOG{1'b0}}};
            if (bus_done) w_next_state = r_need_bus ? ST_BUS : ST_UPD;
         end
         ST_BUS: begin
            bus_req_valid = 1'b1;
            bus_op        = r_bus_op;
            bus_addr      = {r_tag, r_idx, {LINE_LOG{1'b0}}};
            if (bus_done) w_next_state = ST_UPD;
         end
         ST_UPD: begin
            arr_wr_en    = 1'b1;
            arr_index    = r_idx;
            arr_wr_way   = r_way;
            arr_wr_tag   = r_tag;
            arr_wr_mesi  = r_new_mesi;
            arr_wr_plru  = r_new_plru;
            w_next_state = ST_DONE;
         end
         ST_CLR: begin
            arr_wr_en  = 1'b1;
            arr_index  = r_clr_idx;
            arr_wr_way = r_clr_way;
            if ((r_clr_idx == '1) && (r_clr_way == '1)) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            done         = 1'b1;
            resp_hit     = r_hit;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= OP_RD;
         r_tag        <= '0;
         r_idx        <= '0;
         r_way        <= '0;
         r_new_mesi   <= MESI_I;
         r_new_plru   <= '0;
         r_hit        <= 1'b0;
         r_need_bus   <= 1'b0;
         r_bus_op     <= BUS_READ;
         r_wb_tag     <= '0;
         r_clr_idx    <= '0;
         r_clr_way    <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_op      <= decode_op(req_op);
                  r_tag     <= req_addr[ADDR_W-1 -: c_tag_w];
                  r_idx     <= req_addr[LINE_LOG +: c_index_w];
                  r_hit     <= 1'b0;
                  r_clr_idx <= '0;
                  r_clr_way <= '0;
               end
            end
            ST_CMP: begin
               r_way      <= w_tgt_way;
               r_new_mesi <= w_cmp_mesi;
               r_new_plru <= is_cpu_op(r_op) ? w_plru_new : arr_plru;
               r_hit      <= w_hit;
               r_need_bus <= w_cmp_need_bus;
               r_bus_op   <= w_cmp_bus_op;
               r_wb_tag   <= w_tgt_tag;
            end
            ST_BUS: begin
               if (bus_done && (r_bus_op == BUS_READ)) begin
                  if (bus_shared) r_new_mesi <= MESI_S;
                  else            r_new_mesi <= MESI_E;
               end
            end
            ST_CLR: begin
               r_clr_way    <= r_clr_way + 1'b1;
               if (r_clr_way == '1) r_clr_idx <= r_clr_idx + 1'b1;
               r_hit_count  <= '0;
               r_miss_count <= '0;
            end
            ST_DONE: begin
               if (is_cpu_op(r_op)) begin
                  if (r_hit) begin
                     if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
                  end else begin
                     if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Directed bench for cache_ctrl with tag-array and bus models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

   localparam int c_idx_w = 4;   // CACHE_LOG 13: 13-6-3
   localparam int c_tag_w = 22;  // 32-4-6

   logic                 clk, rst;
   logic                 req_valid, req_ready;
   logic [3:0]           req_op;
   logic [31:0]          req_addr;
   logic [c_idx_w-1:0]   arr_index;
   logic                 arr_rd_en, arr_wr_en;
   logic [8*c_tag_w-1:0] arr_tag;
   logic [15:0]          arr_mesi;
   logic [6:0]           arr_plru;
   logic [2:0]           arr_wr_way;
   logic [c_tag_w-1:0]   arr_wr_tag;
   logic [1:0]           arr_wr_mesi;
   logic [6:0]           arr_wr_plru;
   logic                 bus_req_valid, bus_done, bus_shared;
   logic [1:0]           bus_op;
   logic [31:0]          bus_addr;
   logic                 done, resp_hit;
   logic [31:0]          hit_count, miss_count;

   cache_ctrl #(.ADDR_W(32), .CACHE_LOG(13), .LINE_LOG(6), .WAYS(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .arr_index(arr_index), .arr_rd_en(arr_rd_en),
      .arr_tag(arr_tag), .arr_mesi(arr_mesi), .arr_plru(arr_plru),
      .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_tag(arr_wr_tag),
      .arr_wr_mesi(arr_wr_mesi), .arr_wr_plru(arr_wr_plru),
      .bus_req_valid(bus_req_valid), .bus_op(bus_op), .bus_addr(bus_addr),
      .bus_done(bus_done), .bus_shared(bus_shared),
      .done(done), .resp_hit(resp_hit), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Models: tag array, bus responder and event logs.
   logic [c_tag_w-1:0] m_tag [16][8];
   logic [1:0]         m_mesi[16][8];
   logic [6:0]         m_plru[16];
   int                 bus_lat    = 3;
   logic               cfg_shared = 1'b0;
   int                 bus_cnt;
   int                 bus_n, wr_n, rdy_low;
   logic [1:0]         bl_op  [8];
   logic [31:0]        bl_addr[8];
   logic               done_seen, last_hit;
   logic [2:0]         lw_way;
   logic [c_tag_w-1:0] lw_tag;
   logic [1:0]         lw_mesi;
   logic [6:0]         lw_plru;

   initial begin
      for (int s = 0; s < 16; s++) begin
         m_plru[s] = '0;
         for (int w = 0; w < 8; w++) begin
            m_tag[s][w]  = '0;
            m_mesi[s][w] = 2'b00;
         end
      end
      arr_tag = '0; arr_mesi = '0; arr_plru = '0;
      bus_done = 1'b0; bus_shared = 1'b0; bus_cnt = 0;
      bus_n = 0; wr_n = 0; rdy_low = 0; done_seen = 1'b0; last_hit = 1'b0;
      lw_way = '0; lw_tag = '0; lw_mesi = '0; lw_plru = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_done = 1'b0;
            bus_cnt  = 0;
         end else begin
            if (!req_ready) rdy_low++;
            if (done) begin
               done_seen = 1'b1;
               last_hit  = resp_hit;
            end
            if (arr_wr_en) begin
               m_tag[arr_index][arr_wr_way]  = arr_wr_tag;
               m_mesi[arr_index][arr_wr_way] = arr_wr_mesi;
               m_plru[arr_index]             = arr_wr_plru;
               wr_n++;
               lw_way = arr_wr_way; lw_tag = arr_wr_tag;
               lw_mesi = arr_wr_mesi; lw_plru = arr_wr_plru;
            end
            if (arr_rd_en) begin
               for (int w = 0; w < 8; w++) begin
                  arr_tag[w*c_tag_w +: c_tag_w] = m_tag[arr_index][w];
                  arr_mesi[2*w +: 2]            = m_mesi[arr_index][w];
               end
               arr_plru = m_plru[arr_index];
            end
            if (bus_done) begin
               bus_done = 1'b0;
               bus_cnt  = 0;
            end else if (bus_req_valid) begin
               bus_cnt++;
               if (bus_cnt >= bus_lat) begin
                  bus_done   = 1'b1;
                  bus_shared = cfg_shared;
                  if (bus_n < 8) begin
                     bl_op[bus_n]   = bus_op;
                     bl_addr[bus_n] = bus_addr;
                  end
                  bus_n++;
               end
            end else begin
               bus_cnt = 0;
            end
         end
      end
   end

   task automatic do_op(input logic [3:0] op, input logic [31:0] addr);
      int cyc;
      bus_n = 0; wr_n = 0; rdy_low = 0; done_seen = 1'b0;
      cyc = 0;
      while (!req_ready && cyc < 2000) begin
         @(posedge clk); #1; cyc++;
      end
      req_valid = 1'b1; req_op = op; req_addr = addr;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      while (!done_seen && cyc < 2000) begin
         @(posedge clk); #1; cyc++;
      end
      check_eq("op_done", {63'd0, done_seen}, 64'd1);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
      check_eq("rst_hits", {32'd0, hit_count}, 64'd0);
      check_eq("rst_misses", {32'd0, miss_count}, 64'd0);
      check_eq("rst_bus_valid", {63'd0, bus_req_valid}, 64'd0);
      check_eq("rst_wr_en", {63'd0, arr_wr_en}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Cold read miss into an empty set
      do_op(4'd0, 32'h40);
      check_eq("rd_miss_bus_n", bus_n, 1);
      check_eq("rd_miss_bus_op", {62'd0, bl_op[0]}, 64'd0);
      check_eq("rd_miss_bus_addr", {32'd0, bl_addr[0]}, 64'h40);
      check_eq("rd_miss_wr_n", wr_n, 1);
      check_eq("rd_miss_way", {61'd0, lw_way}, 64'd0);
      check_eq("rd_miss_mesi", {62'd0, lw_mesi}, 64'd2);
      check_eq("rd_miss_plru", {57'd0, lw_plru}, 64'h0B);
      check_eq("rd_miss_hit", {63'd0, last_hit}, 64'd0);
      check_eq("rd_miss_cnt", {32'd0, miss_count}, 64'd1);

      // Read hit on the same line
      do_op(4'd0, 32'h40);
      check_eq("rd_hit_bus_n", bus_n, 0);
      check_eq("rd_hit_resp", {63'd0, last_hit}, 64'd1);
      check_eq("rd_hit_cnt", {32'd0, hit_count}, 64'd1);
      check_eq("rd_hit_plru_root", {63'd0, lw_plru[0]}, 64'd1);
      check_eq("rd_hit_mesi", {62'd0, lw_mesi}, 64'd2);

      // Fill set 2 with modified lines, tags 1..8
      for (int t = 1; t <= 8; t++) begin
         do_op(4'd1, 32'(t) * 32'h400 + 32'h80);
         check_eq("fill_bus_op", {62'd0, bl_op[0]}, 64'd1);
         check_eq("fill_way", {61'd0, lw_way}, 64'(t - 1));
         check_eq("fill_mesi", {62'd0, lw_mesi}, 64'd3);
      end

      // Ninth tag evicts the PLRU victim (way 0, tag 1) with a writeback
      do_op(4'd0, 32'h2480);
      check_eq("evict_bus_n", bus_n, 2);
      check_eq("evict_op0", {62'd0, bl_op[0]}, 64'd2);
      check_eq("evict_addr0", {32'd0, bl_addr[0]}, 64'h480);
      check_eq("evict_op1", {62'd0, bl_op[1]}, 64'd0);
      check_eq("evict_addr1", {32'd0, bl_addr[1]}, 64'h2480);
      check_eq("evict_way", {61'd0, lw_way}, 64'd0);
      check_eq("evict_mesi", {62'd0, lw_mesi}, 64'd2);
      check_eq("evict_tag", {42'd0, lw_tag}, 64'd9);
      check_eq("evict_miss_cnt", {32'd0, miss_count}, 64'd10);

      // Shared fill, then write hit on S needs one invalidate
      cfg_shared = 1'b1;
      do_op(4'd0, 32'h3000);
      cfg_shared = 1'b0;
      check_eq("shared_fill_mesi", {62'd0, lw_mesi}, 64'd1);
      do_op(4'd1, 32'h3000);
      check_eq("wr_s_bus_n", bus_n, 1);
      check_eq("wr_s_bus_op", {62'd0, bl_op[0]}, 64'd3);
      check_eq("wr_s_bus_addr", {32'd0, bl_addr[0]}, 64'h3000);
      check_eq("wr_s_mesi", {62'd0, lw_mesi}, 64'd3);
      check_eq("wr_s_hit", {63'd0, last_hit}, 64'd1);
      check_eq("wr_s_hit_cnt", {32'd0, hit_count}, 64'd2);

      // Snoops
      do_op(4'd4, 32'h3000);
      check_eq("snp_rd_bus_n", bus_n, 1);
      check_eq("snp_rd_bus_op", {62'd0, bl_op[0]}, 64'd2);
      check_eq("snp_rd_bus_addr", {32'd0, bl_addr[0]}, 64'h3000);
      check_eq("snp_rd_mesi", {62'd0, lw_mesi}, 64'd1);
      check_eq("snp_rd_hit_cnt", {32'd0, hit_count}, 64'd2);
      check_eq("snp_rd_miss_cnt", {32'd0, miss_count}, 64'd11);
      do_op(4'd3, 32'h3000);
      check_eq("snp_inv_s_wr_n", wr_n, 1);
      check_eq("snp_inv_s_mesi", {62'd0, lw_mesi}, 64'd0);
      do_op(4'd3, 32'h7000);
      check_eq("snp_inv_miss_wr_n", wr_n, 0);
      check_eq("snp_inv_miss_bus_n", bus_n, 0);

      // Unlisted opcode retires as a no-op
      do_op(4'd7, 32'h40);
      check_eq("nop_wr_n", wr_n, 0);
      check_eq("nop_resp", {63'd0, last_hit}, 64'd0);

      // Clear walks 16 sets x 8 ways, plus the DONE cycle
      do_op(4'd8, 32'h0);
      check_eq("clr_ready_low", rdy_low, 129);
      check_eq("clr_wr_n", wr_n, 128);
      check_eq("clr_mesi", {62'd0, lw_mesi}, 64'd0);
      check_eq("clr_hit_cnt", {32'd0, hit_count}, 64'd0);
      check_eq("clr_miss_cnt", {32'd0, miss_count}, 64'd0);
      do_op(4'd0, 32'h40);
      check_eq("post_clr_hit", {63'd0, last_hit}, 64'd0);
      check_eq("post_clr_bus_n", bus_n, 1);
      check_eq("post_clr_miss_cnt", {32'd0, miss_count}, 64'd1);

      // Reset while a bus read is outstanding
      bus_lat = 50;
      req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h8000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      while (!bus_req_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      check_eq("bus_started", {63'd0, bus_req_valid}, 64'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_bus_valid", {63'd0, bus_req_valid}, 64'd0);
      check_eq("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      check_eq("rst_mid_wr_en", {63'd0, arr_wr_en}, 64'd0);
      check_eq("rst_mid_miss_cnt", {32'd0, miss_count}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_lat = 3;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
